// File: rtl/button_conditioner.sv
// Push-button front end: per-channel two-flop synchroniser, debounce counter,
// and registered press / release / long-press pulses. Channels are independent.
module button_conditioner #(
  parameter int NUM_BUTTONS       = 2,
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int LONG_PRESS_CYCLES = 50000000
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_BUTTONS-1:0] buttons_raw,
  output logic [NUM_BUTTONS-1:0] buttons_level,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic [NUM_BUTTONS-1:0] release_pulse,
  output logic [NUM_BUTTONS-1:0] long_pulse
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
  // The hold counter reaches LONG_PRESS_CYCLES on the same edge the pulse is
  // registered, so the pulse is armed one count earlier.
  localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic [NUM_BUTTONS-1:0] sync1_q, sync2_q;
  logic [NUM_BUTTONS-1:0] level_q, level_d;
  logic [NUM_BUTTONS-1:0] press_q, press_d;
  logic [NUM_BUTTONS-1:0] release_q, release_d;
  logic [NUM_BUTTONS-1:0] long_q, long_d;
  logic [DB_W-1:0]        db_cnt_q   [NUM_BUTTONS];
  logic [DB_W-1:0]        db_cnt_d   [NUM_BUTTONS];
  logic [HOLD_W-1:0]      hold_cnt_q [NUM_BUTTONS];
  logic [HOLD_W-1:0]      hold_cnt_d [NUM_BUTTONS];

  // Two-flop synchroniser bringing the raw pads into the clock domain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= buttons_raw;
      sync2_q <= sync1_q;
    end
  end

  // Next-state for debounce, edge pulses and hold timing, per channel.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      db_cnt_d[i]   = db_cnt_q[i];
      hold_cnt_d[i] = hold_cnt_q[i];

      // Any sample agreeing with the current level restarts the qualification.
      if (sync2_q[i] == level_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        db_cnt_d[i]  = '0;
        level_d[i]   = sync2_q[i];
        press_d[i]   = sync2_q[i];
        release_d[i] = ~sync2_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end

      // Saturating at the limit keeps long_pulse from repeating while held.
      if (!level_q[i]) begin
        hold_cnt_d[i] = '0;
      end else if (hold_cnt_q[i] != HOLD_MAX) begin
        hold_cnt_d[i] = hold_cnt_q[i] + HOLD_W'(1);
      end

      long_d[i] = level_q[i] && (hold_cnt_q[i] == HOLD_FIRE);
    end
  end

  // Debounced level, counters and registered pulse outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        db_cnt_q[i]   <= '0;
        hold_cnt_q[i] <= '0;
      end
    end else begin
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        db_cnt_q[i]   <= db_cnt_d[i];
        hold_cnt_q[i] <= hold_cnt_d[i];
      end
    end
  end

  assign buttons_level = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: sliding-window reference model checked every
// cycle, directed scenarios with literal edge numbers, then random stimulus.
module tb_button_conditioner;

  localparam int N    = 2;
  localparam int DEB  = 4;
  localparam int LONG = 10;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] buttons_raw = '0;
  logic [N-1:0] buttons_level, press_pulse, release_pulse, long_pulse;

  int n_checks = 0;
  int n_pass   = 0;

  button_conditioner #(
    .NUM_BUTTONS      (N),
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LONG)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .buttons_raw  (buttons_raw),
    .buttons_level(buttons_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: hist[k] is the raw value sampled k edges ago, so the
  // synchronised value seen at this edge is hist[2]. The level flips when the
  // last DEB synchronised samples all disagree with it.
  logic [N-1:0] hist [DEB+2];
  logic [N-1:0] m_level = '0, m_press = '0, m_rel = '0, m_long = '0;
  int           age [N];

  always @(posedge clock) begin
    m_press = '0;
    m_rel   = '0;
    m_long  = '0;
    if (!reset_n) begin
      for (int k = 0; k < DEB + 2; k++) hist[k] = '0;
      m_level = '0;
      for (int i = 0; i < N; i++) age[i] = -1;
    end else begin
      for (int k = DEB + 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = buttons_raw;
      for (int i = 0; i < N; i++) begin
        bit flip;
        flip = 1'b1;
        for (int k = 2; k < DEB + 2; k++)
          if (hist[k][i] == m_level[i]) flip = 1'b0;
        // age = edges since the press; reaching LONG with no release in
        // between yields exactly one long pulse
        if (age[i] >= 0) begin
          age[i]++;
          if (age[i] == LONG) begin
            m_long[i] = 1'b1;
            age[i] = -1;
          end
        end
        if (flip) begin
          if (m_level[i]) begin
            m_rel[i] = 1'b1;
            age[i] = -1;
          end else begin
            m_press[i] = 1'b1;
            age[i] = 0;
          end
          m_level[i] = ~m_level[i];
        end
      end
    end
  end

  // Every cycle: DUT outputs against the model (all zero while in reset).
  always @(negedge clock) begin
    check("level",   buttons_level, reset_n ? m_level : '0);
    check("press",   press_pulse,   reset_n ? m_press : '0);
    check("release", release_pulse, reset_n ? m_rel   : '0);
    check("long",    long_pulse,    reset_n ? m_long  : '0);
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic idle(input int n);
    buttons_raw = '0;
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int nlong, long_edge, npress, nrel;

    // reset state
    for (int k = 0; k < 3; k++) tick();
    check("reset_level", buttons_level, 2'b00);
    check("reset_press", press_pulse, 2'b00);
    reset_n = 1'b1;
    idle(4);

    // clean press on channel 0
    buttons_raw[0] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 5) check("clean_level_e5", buttons_level, 2'b00);
      if (e == 6) begin
        check("clean_level_e6", buttons_level, 2'b01);
        check("clean_press_e6", press_pulse, 2'b01);
      end
      if (e == 7) check("clean_press_e7", press_pulse, 2'b00);
    end
    idle(12);
    check("clean_released", buttons_level, 2'b00);

    // bounce: toggle every 2 cycles, never stable for DEB samples
    npress = 0;
    for (int e = 0; e < 20; e++) begin
      buttons_raw[0] = e[1];
      tick();
      if (buttons_level != 0 || press_pulse != 0 || release_pulse != 0 || long_pulse != 0)
        npress++;
    end
    idle(10);
    check_int("bounce_activity", npress, 0);

    // long press on channel 1
    nlong = 0;
    long_edge = 0;
    buttons_raw[1] = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (e == 6) check("long_press_e6", press_pulse, 2'b10);
      if (long_pulse[1]) begin
        nlong++;
        long_edge = e;
      end
    end
    check_int("long_count", nlong, 1);
    check_int("long_edge", long_edge, 16);
    buttons_raw[1] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 5) check("long_rel_e5", release_pulse, 2'b00);
      if (e == 6) check("long_rel_e6", release_pulse, 2'b10);
    end
    idle(6);

    // short press: the level stays up as long as raw did, so keep it under LONG
    npress = 0;
    nrel = 0;
    nlong = 0;
    buttons_raw[0] = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      if (e == 9) buttons_raw[0] = 1'b0;
      tick();
      if (press_pulse[0]) npress++;
      if (release_pulse[0]) nrel++;
      if (long_pulse[0]) nlong++;
      if (e == 14) check("short_rel_e14", release_pulse, 2'b01);
    end
    check_int("short_press_cnt", npress, 1);
    check_int("short_rel_cnt", nrel, 1);
    check_int("short_long_cnt", nlong, 0);

    // simultaneous press, staggered release
    buttons_raw = 2'b11;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 5) check("simul_press_e5", press_pulse, 2'b00);
      if (e == 6) check("simul_press_e6", press_pulse, 2'b11);
    end
    buttons_raw[0] = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 3) buttons_raw[1] = 1'b0;
      if (e == 6) check("simul_rel0", release_pulse, 2'b01);
      if (e == 9) check("simul_rel1", release_pulse, 2'b10);
    end
    idle(6);

    // reset mid-debounce with raw held high
    buttons_raw[0] = 1'b1;
    for (int e = 1; e <= 3; e++) tick();
    reset_n = 1'b0;
    #1;
    check("rst_level", buttons_level, 2'b00);
    check("rst_press", press_pulse, 2'b00);
    check("rst_release", release_pulse, 2'b00);
    check("rst_long", long_pulse, 2'b00);
    tick();
    tick();
    reset_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 5) check("rst_press_e5", press_pulse, 2'b00);
      if (e == 6) check("rst_press_e6", press_pulse, 2'b01);
    end
    idle(14);

    // random stimulus with occasional resets
    for (int s = 0; s < 250; s++) begin
      int len;
      buttons_raw = N'($urandom_range(0, 3));
      len = $urandom_range(1, 22);
      if ($urandom_range(0, 29) == 0) begin
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
      end
      for (int k = 0; k < len; k++) tick();
    end
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
